// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the cpu core and the front-panel loader.
// Each access holds its strobe for MEM_LAT cycles, then pulses a one-cycle ack to the winner.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned MAX_WAIT = 4,
    parameter logic [1:0]  RUN_CODE = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cpustate,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        pnl_req,
    input  logic        pnl_we,
    input  logic [15:0] pnl_addr,
    input  logic [7:0]  pnl_wdata,
    output logic        pnl_ack,
    output logic [7:0]  pnl_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic [1:0]  grant
);
    localparam int unsigned       WaitW   = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0]  WaitMax = WaitW'(MAX_WAIT);
    localparam logic [3:0]        LatLast = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

    state_e           state_q;
    logic [3:0]       lat_q;
    logic [WaitW-1:0] wait_q;
    logic             we_q;
    logic [15:0]      addr_q;
    logic [7:0]       wdata_q;
    logic [1:0]       grant_q;
    logic             busy_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic             cpu_ack_q;
    logic             pnl_ack_q;
    logic [7:0]       cpu_rdata_q;
    logic [7:0]       pnl_rdata_q;

    logic cpu_elig;
    logic take_pnl;
    logic take_cpu;
    logic sel_we;

    always_comb begin
        cpu_elig = cpu_req && (cpustate == RUN_CODE);
        // The panel wins outright when the cpu is not eligible, or once it has been starved.
        take_pnl = pnl_req && (!cpu_elig || (wait_q == WaitMax));
        take_cpu = cpu_elig && !take_pnl;
        sel_we   = take_pnl ? pnl_we : cpu_we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            wait_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pnl_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            pnl_rdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            pnl_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (take_pnl || !pnl_req) begin
                        wait_q <= '0;
                    end else if (take_cpu && (wait_q != WaitMax)) begin
                        wait_q <= wait_q + 1'b1;
                    end
                    if (take_pnl || take_cpu) begin
                        we_q        <= sel_we;
                        addr_q      <= take_pnl ? pnl_addr : cpu_addr;
                        wdata_q     <= take_pnl ? pnl_wdata : cpu_wdata;
                        grant_q     <= take_pnl ? 2'b10 : 2'b01;
                        busy_q      <= 1'b1;
                        mem_read_q  <= !sel_we;
                        mem_write_q <= sel_we;
                        lat_q       <= '0;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    if (lat_q == LatLast) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (!we_q && grant_q[1]) pnl_rdata_q <= mem_rdata;
                        if (!we_q && grant_q[0]) cpu_rdata_q <= mem_rdata;
                        pnl_ack_q   <= grant_q[1];
                        cpu_ack_q   <= grant_q[0];
                        state_q     <= StAck;
                    end else begin
                        lat_q <= lat_q + 4'd1;
                    end
                end
                StAck: begin
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign pnl_ack   = pnl_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign pnl_rdata = pnl_rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter against a RAM model and a
// behavioural expectation model (arbitration order, access timing, memory contents).
module tb_mem_port_arbiter;
    localparam int MEM_LAT  = 2;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance (MEM_LAT=2)
    logic [1:0]  cpustate = 2'b00;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        pnl_req = 1'b0, pnl_we = 1'b0;
    logic [15:0] pnl_addr = '0;
    logic [7:0]  pnl_wdata = '0;
    logic        pnl_ack;
    logic [7:0]  pnl_rdata;
    logic        mem_read, mem_write, busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [1:0]  grant;

    // Second instance (MEM_LAT=1), cpu side only
    logic [1:0]  cpustate_b = 2'b01;
    logic        cpu_req_b = 1'b0;
    logic [15:0] cpu_addr_b = '0;
    logic        cpu_ack_b, pnl_ack_b;
    logic [7:0]  cpu_rdata_b, pnl_rdata_b;
    logic        mem_read_b, mem_write_b, busy_b;
    logic [15:0] mem_addr_b;
    logic [7:0]  mem_wdata_b, mem_rdata_b;
    logic [1:0]  grant_b;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT), .RUN_CODE(2'b01)) u_dut (
        .clk(clk), .rst(rst), .cpustate(cpustate),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
        .pnl_ack(pnl_ack), .pnl_rdata(pnl_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    mem_port_arbiter #(.MEM_LAT(1), .MAX_WAIT(MAX_WAIT), .RUN_CODE(2'b01)) u_dut_b (
        .clk(clk), .rst(rst), .cpustate(cpustate_b),
        .cpu_req(cpu_req_b), .cpu_we(1'b0), .cpu_addr(cpu_addr_b), .cpu_wdata(8'h00),
        .cpu_ack(cpu_ack_b), .cpu_rdata(cpu_rdata_b),
        .pnl_req(1'b0), .pnl_we(1'b0), .pnl_addr(16'h0000), .pnl_wdata(8'h00),
        .pnl_ack(pnl_ack_b), .pnl_rdata(pnl_rdata_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b), .grant(grant_b)
    );

    // Environment RAM shared by both instances; the bench preloads through pl_*.
    logic [7:0]  ram [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    assign mem_rdata   = ram[mem_addr];
    assign mem_rdata_b = ram[mem_addr_b];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        if (pl_en) ram[pl_addr] <= pl_data;
    end

    // Reference memory contents, updated from the bench's own view of each transaction.
    logic [7:0] ref_mem [int];

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_read && mem_write) viol++;
            if ((mem_read || mem_write) && !busy) viol++;
            if (mem_read_b && mem_write_b) viol++;
            if ((mem_read_b || mem_write_b) && !busy_b) viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[int'(a)] = d;
        tick();
        pl_en = 1'b0;
    endtask

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    // Drives one request to completion and reports what was seen on the bus.
    task automatic run_access(input bit pnl, input bit we, input logic [15:0] addr,
                              input logic [7:0] wd, output int n_ack, output int n_rd,
                              output int n_wr, output int bad_bus, output logic [1:0] gnt,
                              output logic [7:0] rdata);
        bit done;
        n_ack = -1; n_rd = 0; n_wr = 0; bad_bus = 0; gnt = 2'b00; rdata = 8'hxx; done = 0;
        for (int i = 0; i < 20 && busy; i++) tick();
        if (pnl) begin
            pnl_req = 1'b1; pnl_we = we; pnl_addr = addr; pnl_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end
        for (int n = 1; n <= 40 && !done; n++) begin
            tick();
            if (mem_read) n_rd++;
            if (mem_write) n_wr++;
            if ((mem_read || mem_write) &&
                (mem_addr !== addr || (mem_write && mem_wdata !== wd))) bad_bus++;
            if (gnt == 2'b00) gnt = grant;
            if (pnl ? pnl_ack : cpu_ack) begin
                n_ack = n; rdata = pnl ? pnl_rdata : cpu_rdata; done = 1;
            end else if (grant != 2'b00) begin
                // Request fields are latched at grant; scrambling them must not matter.
                if (pnl) begin
                    pnl_addr = 16'($urandom); pnl_wdata = 8'($urandom); pnl_we = 1'($urandom);
                end else begin
                    cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom);
                end
            end
        end
        if (pnl) pnl_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({grant, busy, mem_read, mem_write, cpu_ack, pnl_ack, cpu_rdata, pnl_rdata,
             mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b busy=%b rd=%b wr=%b addr=%h, required all 0",
                     grant, busy, mem_read, mem_write, mem_addr);
        end
        checks++;
        if ({grant_b, busy_b, mem_read_b, mem_write_b, cpu_ack_b, cpu_rdata_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_b: grant=%b busy=%b, required 0", grant_b, busy_b);
        end
    endtask

    task automatic test_panel_write();
        int n_ack, n_rd, n_wr, bad;
        logic [1:0] g;
        logic [7:0] rd;
        cpustate = 2'b00;
        run_access(1'b1, 1'b1, 16'h0010, 8'h5A, n_ack, n_rd, n_wr, bad, g, rd);
        ref_mem[16'h0010] = 8'h5A;
        checks++;
        if (n_wr !== MEM_LAT || n_rd !== 0) begin
            errors++;
            $display("FAIL pnl_wr_strobes: wr=%0d rd=%0d, required wr=%0d rd=0", n_wr, n_rd, MEM_LAT);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL pnl_wr_bus: %0d bad bus cycles, required 0", bad);
        end
        checks++;
        if (g !== 2'b10) begin errors++; $display("FAIL pnl_wr_grant: %b, required 10", g); end
        checks++;
        if (n_ack !== MEM_LAT + 1) begin
            errors++; $display("FAIL pnl_wr_latency: ack at %0d, required %0d", n_ack, MEM_LAT + 1);
        end
        tick();
        checks++;
        if (pnl_ack !== 1'b0) begin errors++; $display("FAIL pnl_ack_width: still %b", pnl_ack); end
        checks++;
        if (ram[16'h0010] !== ref_rd(16'h0010)) begin
            errors++; $display("FAIL pnl_wr_ram: %h, required %h", ram[16'h0010], ref_rd(16'h0010));
        end
    endtask

    task automatic test_cpu_read();
        int n_ack, n_rd, n_wr, bad;
        logic [1:0] g;
        logic [7:0] rd;
        preload(16'h0020, 8'hC3);
        cpustate = 2'b01;
        run_access(1'b0, 1'b0, 16'h0020, 8'h00, n_ack, n_rd, n_wr, bad, g, rd);
        checks++;
        if (n_rd !== MEM_LAT || n_wr !== 0 || bad !== 0) begin
            errors++;
            $display("FAIL cpu_rd_strobes: rd=%0d wr=%0d bad=%0d, required rd=%0d wr=0 bad=0",
                     n_rd, n_wr, bad, MEM_LAT);
        end
        checks++;
        if (g !== 2'b01) begin errors++; $display("FAIL cpu_rd_grant: %b, required 01", g); end
        checks++;
        if (n_ack !== MEM_LAT + 1) begin
            errors++; $display("FAIL cpu_rd_latency: ack at %0d, required %0d", n_ack, MEM_LAT + 1);
        end
        checks++;
        if (rd !== ref_rd(16'h0020)) begin
            errors++; $display("FAIL cpu_rd_data: %h, required %h", rd, ref_rd(16'h0020));
        end
        // rdata must survive idle cycles and an intervening write.
        repeat (3) tick();
        run_access(1'b0, 1'b1, 16'h0030, 8'h77, n_ack, n_rd, n_wr, bad, g, rd);
        ref_mem[16'h0030] = 8'h77;
        checks++;
        if (cpu_rdata !== 8'hC3) begin
            errors++; $display("FAIL cpu_rdata_hold: %h, required c3", cpu_rdata);
        end
    endtask

    task automatic test_random();
        int n_ack, n_rd, n_wr, bad;
        logic [1:0] g;
        logic [7:0] rd;
        bit pnl, we;
        logic [15:0] a;
        logic [7:0] wd;
        for (int i = 0; i < 16; i++) preload(16'h0400 + 16'(i), 8'($urandom));
        for (int i = 0; i < 24; i++) begin
            pnl = 1'($urandom); we = 1'($urandom);
            a = 16'h0400 + 16'($urandom_range(0, 15));
            wd = 8'($urandom);
            cpustate = pnl ? 2'($urandom) : 2'b01;
            run_access(pnl, we, a, wd, n_ack, n_rd, n_wr, bad, g, rd);
            checks++;
            if (n_ack !== MEM_LAT + 1 || bad !== 0 || g !== (pnl ? 2'b10 : 2'b01) ||
                n_rd !== (we ? 0 : MEM_LAT) || n_wr !== (we ? MEM_LAT : 0)) begin
                errors++;
                $display("FAIL rand_txn%0d: ack=%0d rd=%0d wr=%0d bad=%0d gnt=%b, required ack=%0d",
                         i, n_ack, n_rd, n_wr, bad, g, MEM_LAT + 1);
            end
            if (we) begin
                ref_mem[int'(a)] = wd;
            end else begin
                checks++;
                if (rd !== ref_rd(a)) begin
                    errors++;
                    $display("FAIL rand_rdata%0d: addr=%h got %h, required %h", i, a, rd, ref_rd(a));
                end
            end
        end
    endtask

    task automatic test_non_run();
        int bad, n_ack;
        bad = 0; n_ack = -1;
        tick();
        cpustate = 2'b00; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        repeat (20) begin
            tick();
            if (grant !== 2'b00 || mem_read || mem_write || cpu_ack || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL nonrun_stall: %0d active cycles, required 0", bad); end
        cpustate = 2'b01;
        for (int n = 1; n <= 20 && n_ack < 0; n++) begin
            tick();
            if (cpu_ack) n_ack = n;
        end
        cpu_req = 1'b0;
        checks++;
        if (n_ack !== MEM_LAT + 1) begin
            errors++; $display("FAIL nonrun_release: ack at %0d, required %0d", n_ack, MEM_LAT + 1);
        end
        checks++;
        if (cpu_rdata !== ref_rd(16'h0020)) begin
            errors++; $display("FAIL nonrun_rdata: %h, required %h", cpu_rdata, ref_rd(16'h0020));
        end
    endtask

    task automatic test_reset_mid();
        int acks, n_ack;
        acks = 0; n_ack = -1;
        repeat (2) tick();
        cpustate = 2'b01; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0405;
        tick();
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("FAIL rstmid_started: rd=%b, required 1", mem_read); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({mem_read, mem_write, grant, busy, cpu_ack} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: rd=%b wr=%b grant=%b busy=%b, required 0",
                     mem_read, mem_write, grant, busy);
        end
        repeat (3) begin
            tick();
            if (cpu_ack || pnl_ack) acks++;
        end
        #3 rst = 1'b1;
        for (int n = 1; n <= 20 && n_ack < 0; n++) begin
            tick();
            if (cpu_ack) n_ack = n;
        end
        cpu_req = 1'b0;
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL rstmid_noack: %0d acks, required 0", acks); end
        checks++;
        if (n_ack !== MEM_LAT + 1) begin
            errors++; $display("FAIL rstmid_reissue: ack at %0d, required %0d", n_ack, MEM_LAT + 1);
        end
        checks++;
        if (cpu_rdata !== ref_rd(16'h0405)) begin
            errors++; $display("FAIL rstmid_rdata: %h, required %h", cpu_rdata, ref_rd(16'h0405));
        end
    endtask

    task automatic test_starvation();
        logic [1:0] seen [$];
        logic [1:0] exp_g [10];
        logic [1:0] prev;
        int w;
        w = 0;
        for (int k = 0; k < 10; k++) begin
            if (w == MAX_WAIT) begin exp_g[k] = 2'b10; w = 0; end
            else begin exp_g[k] = 2'b01; w++; end
        end
        repeat (3) tick();
        cpustate = 2'b01;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
        pnl_req = 1'b1; pnl_we = 1'b0; pnl_addr = 16'h0401;
        prev = 2'b00;
        for (int n = 0; n < 120 && seen.size() < 10; n++) begin
            tick();
            if (grant != 2'b00 && prev == 2'b00) seen.push_back(grant);
            prev = grant;
        end
        cpu_req = 1'b0; pnl_req = 1'b0;
        repeat (6) tick();
        checks++;
        if (seen.size() !== 10) begin
            errors++; $display("FAIL starve_count: %0d grants, required 10", seen.size());
        end
        for (int k = 0; k < 10 && k < seen.size(); k++) begin
            checks++;
            if (seen[k] !== exp_g[k]) begin
                errors++; $display("FAIL starve_grant%0d: %b, required %b", k, seen[k], exp_g[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks, last, t;
        for (int i = 0; i < 8; i++) preload(16'h0500 + 16'(i), 8'($urandom));
        acks = 0; last = 0; t = 0;
        cpustate_b = 2'b01; cpu_addr_b = 16'h0500; cpu_req_b = 1'b1;
        while (t < 60 && acks < 8) begin
            tick();
            t++;
            if (cpu_ack_b) begin
                checks++;
                if ((t - last) !== ((acks == 0) ? 2 : 3)) begin
                    errors++;
                    $display("FAIL b2b_interval%0d: %0d cycles, required %0d",
                             acks, t - last, (acks == 0) ? 2 : 3);
                end
                checks++;
                if (cpu_rdata_b !== ref_rd(16'h0500 + 16'(acks))) begin
                    errors++;
                    $display("FAIL b2b_rdata%0d: %h, required %h",
                             acks, cpu_rdata_b, ref_rd(16'h0500 + 16'(acks)));
                end
                last = t;
                acks++;
                cpu_addr_b = 16'h0500 + 16'(acks);
            end
        end
        cpu_req_b = 1'b0;
        checks++;
        if (acks !== 8) begin errors++; $display("FAIL b2b_count: %0d acks, required 8", acks); end
    endtask

    task automatic test_strobe_rules();
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL strobe_rules: %0d violations, required 0", viol);
        end
    endtask

    initial begin
        #3;
        test_reset();
        #10 rst = 1'b1;
        tick();
        test_panel_write();
        test_cpu_read();
        test_random();
        test_non_run();
        test_reset_mid();
        test_starvation();
        test_back_to_back();
        test_strobe_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
